// File: rtl/prio_arb_rr.sv
// prio_arb_rr: registered WIDTH-bit priority arbiter that holds each grant under a Valid/Ack handshake.
// Define PRIO_ARB_RR_EN for round-robin selection; leave it undefined for fixed MSB-first priority.
module prio_arb_rr #(
  parameter int WIDTH = 16,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic [WIDTH-1:0] Din,
  input  logic             Ack,
  output logic             Valid,
  output logic [IDXW-1:0]  Dout,
  output logic [WIDTH-1:0] Gnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, next_state;
  logic             valid_d;
  logic [IDXW-1:0]  dout_d;
  logic [WIDTH-1:0] gnt_d;
  logic             req;
  logic             xfer;
  logic [IDXW-1:0]  winner;

  // Index of the highest set bit; callers guarantee vec is non-zero when it matters.
  function automatic logic [IDXW-1:0] highest(input logic [WIDTH-1:0] vec);
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] sh;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sh = vec >> i;
      if (sh[0]) idx = IDXW'(i);
    end
    return idx;
  endfunction

  assign req  = En && (Din != '0);
  assign xfer = (state == BUSY) && Ack;

`ifdef PRIO_ARB_RR_EN
  logic [IDXW-1:0]  last;
  logic [IDXW-1:0]  last_eff;
  logic [IDXW-1:0]  start;
  logic [WIDTH-1:0] low_mask;
  logic [WIDTH-1:0] low_req;

  // Search bits [start:0] first; if none are set, the highest bit overall is the wrapped winner.
  always_comb begin
    last_eff = xfer ? Dout : last;
    start    = (last_eff == '0) ? IDXW'(WIDTH - 1) : last_eff - IDXW'(1);
    low_mask = {WIDTH{1'b1}} >> (IDXW'(WIDTH - 1) - start);
    low_req  = Din & low_mask;
    winner   = (low_req != '0) ? highest(low_req) : highest(Din);
  end

  always_ff @(posedge clk) begin
    if (rst)
      last <= '0;
    else if (xfer)
      last <= Dout;
  end
`else
  assign winner = highest(Din);
`endif

  always_comb begin
    next_state = state;
    valid_d    = Valid;
    dout_d     = Dout;
    gnt_d      = Gnt;
    case (state)
      IDLE: begin
        if (req) begin
          next_state = BUSY;
          valid_d    = 1'b1;
          dout_d     = winner;
          gnt_d      = WIDTH'(1) << winner;
        end
      end
      BUSY: begin
        // Without Ack the grant is frozen regardless of En and Din.
        if (Ack) begin
          if (req) begin
            valid_d = 1'b1;
            dout_d  = winner;
            gnt_d   = WIDTH'(1) << winner;
          end else begin
            next_state = IDLE;
            valid_d    = 1'b0;
            gnt_d      = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      Valid <= 1'b0;
      Dout  <= '0;
      Gnt   <= '0;
    end else begin
      state <= next_state;
      Valid <= valid_d;
      Dout  <= dout_d;
      Gnt   <= gnt_d;
    end
  end

endmodule

// File: tb/tb_prio_arb_rr.sv
// tb_prio_arb_rr: directed plus randomized checks of prio_arb_rr against a behavioural arbiter model.
// Follows PRIO_ARB_RR_EN the same way the design does.
module tb_prio_arb_rr;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         En  = 1'b0;
  logic         Ack = 1'b0;
  logic [W-1:0] Din = '0;
  logic         Valid;
  logic [3:0]   Dout;
  logic [W-1:0] Gnt;

  int   total   = 0;
  int   bad     = 0;
  logic checkOn = 1'b0;

  logic mvalid = 1'b0;
  int   mdout  = 0;
  int   mlast  = 0;

  prio_arb_rr #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .En    (En),
    .Din   (Din),
    .Ack   (Ack),
    .Valid (Valid),
    .Dout  (Dout),
    .Gnt   (Gnt)
  );

  always #5 clk = ~clk;

  // Walk downward from the position just below the last served requester, wrapping around.
  function automatic int pick(input logic [W-1:0] din, input int lastv);
    int start;
`ifdef PRIO_ARB_RR_EN
    start = (lastv + W - 1) % W;
`else
    start = W - 1;
`endif
    for (int k = 0; k < W; k++) begin
      int idx;
      idx = (start - k + W) % W;
      if (din[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic logic [W-1:0] modelGnt();
    logic [W-1:0] g;
    g = '0;
    if (mvalid) g[mdout] = 1'b1;
    return g;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mvalid <= 1'b0;
      mdout  <= 0;
      mlast  <= 0;
    end else if (!mvalid) begin
      if (En && Din != '0) begin
        mvalid <= 1'b1;
        mdout  <= pick(Din, mlast);
      end
    end else if (Ack) begin
      mlast <= mdout;
      if (En && Din != '0)
        mdout <= pick(Din, mdout);
      else
        mvalid <= 1'b0;
    end
  end

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      cmp("cyc_valid", 64'(Valid), 64'(mvalid));
      cmp("cyc_dout", 64'(Dout), 64'(mdout));
      cmp("cyc_gnt", 64'(Gnt), 64'(modelGnt()));
      cmp("cyc_onehot", 64'(!Valid || $onehot(Gnt)), 64'(1));
    end
  end

  task automatic applyStimulus(input logic r, input logic e, input logic [W-1:0] d, input logic a);
    rst = r;
    En  = e;
    Din = d;
    Ack = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic ev, input int ed, input logic [W-1:0] eg);
    cmp({name, "_valid"}, 64'(Valid), 64'(ev));
    cmp({name, "_dout"}, 64'(Dout), 64'(ed));
    cmp({name, "_gnt"}, 64'(Gnt), 64'(eg));
    cmp({name, "_model"}, 64'(mvalid), 64'(ev));
    cmp({name, "_mdout"}, 64'(mdout), 64'(ed));
  endtask

  initial begin
    checkOn = 1'b1;

    // Reset holds everything at zero even with every requester active.
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b0);
    checkOutput("rst0", 1'b0, 0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b0);
    checkOutput("rst1", 1'b0, 0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0);
    checkOutput("rst_rel", 1'b1, 15, 16'h8000);

    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0041, 1'b0);
    checkOutput("hold_g", 1'b1, 6, 16'h0040);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h8000, 1'b0);
      checkOutput("hold_keep", 1'b1, 6, 16'h0040);
    end
    applyStimulus(1'b0, 1'b1, 16'h8000, 1'b1);
    checkOutput("hold_next", 1'b1, 15, 16'h8000);

    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h8101, 1'b1);
    checkOutput("seq0", 1'b1, 15, 16'h8000);
`ifdef PRIO_ARB_RR_EN
    applyStimulus(1'b0, 1'b1, 16'h8101, 1'b1);
    checkOutput("seq1", 1'b1, 8, 16'h0100);
    applyStimulus(1'b0, 1'b1, 16'h8101, 1'b1);
    checkOutput("seq2", 1'b1, 0, 16'h0001);
    applyStimulus(1'b0, 1'b1, 16'h8101, 1'b1);
    checkOutput("seq3", 1'b1, 15, 16'h8000);
    applyStimulus(1'b0, 1'b1, 16'h8101, 1'b1);
    checkOutput("seq4", 1'b1, 8, 16'h0100);
`else
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h8101, 1'b1);
      checkOutput("seq_fixed", 1'b1, 15, 16'h8000);
    end
`endif

    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'hFFFF, 1'b0);
    checkOutput("en_off", 1'b0, 0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'hFFFF, 1'b1);
    checkOutput("ack_idle", 1'b0, 0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h0004, 1'b0);
    checkOutput("en_grant", 1'b1, 2, 16'h0004);
    applyStimulus(1'b0, 1'b0, 16'h0004, 1'b0);
    checkOutput("en_drop_hold", 1'b1, 2, 16'h0004);
    applyStimulus(1'b0, 1'b0, 16'h0004, 1'b1);
    checkOutput("en_drop_ack", 1'b0, 2, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
    checkOutput("empty", 1'b0, 2, 16'h0000);

    // Reset in the middle of a round-robin sequence must clear the rotation point.
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h8101, 1'b1);
    checkOutput("mid_g0", 1'b1, 15, 16'h8000);
    applyStimulus(1'b0, 1'b1, 16'h8101, 1'b1);
`ifdef PRIO_ARB_RR_EN
    checkOutput("mid_g1", 1'b1, 8, 16'h0100);
`else
    checkOutput("mid_g1", 1'b1, 15, 16'h8000);
`endif
    applyStimulus(1'b1, 1'b1, 16'h8101, 1'b1);
    checkOutput("mid_rst", 1'b0, 0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h8101, 1'b0);
    checkOutput("mid_after", 1'b1, 15, 16'h8000);

    for (int i = 0; i < 3000; i++) begin
      logic         r, e, a;
      logic [W-1:0] d;
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 9) != 0);
      a = $urandom_range(0, 2) != 0;
      d = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom & $urandom);
      applyStimulus(r, e, d, a);
    end

    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prio_arb_rr.md
# prio_arb_rr

Parametrised, registered priority arbiter: the sequential successor to the 16-bit priority encoder. It encodes a WIDTH-bit request vector into the index and one-hot mask of the winning requester. The grant is held stable under a Valid/Ack handshake. Round-robin fairness is an optional compiled-in mode. It sits between a bank of requesters and a shared resource that consumes one grant at a time.

## Interface
- WIDTH, 16, number of requesters; legal range 2..64
- IDXW, $clog2(WIDTH), width of the encoded index
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  reset; synchronous to clk, active-high
- En  input  1  arbitration enable; 1 = new grants may be issued
- Din  input  WIDTH  request vector; bit i = requester i wants the resource
- Ack  input  1  consumer accepts the current grant; meaningful only while Valid=1
- Valid  output  1  a grant is being presented
- Dout  output  IDXW  binary index of the granted requester
- Gnt  output  WIDTH  one-hot grant mask; equals 1<<Dout while Valid=1, otherwise 0

## Operation
- All outputs are registered. Under rst: Valid=0, Dout=0, Gnt=0, FSM=IDLE, Last=0.
- Two-state FSM:
  - IDLE → BUSY when En=1 and Din≠0. On that edge the winner is loaded into Dout and Gnt, and Valid is set to 1.
  - BUSY, Ack=0: Dout, Gnt and Valid hold. Din and En are ignored, so the grant is never withdrawn or changed.
  - BUSY, Ack=1 (transfer), then on the same edge:
    - if En=1 and Din≠0: re-arbitrate using the current Din and the updated Last, and stay BUSY. Back-to-back grants are allowed, with no bubble.
    - otherwise: go to IDLE with Valid=0 and Gnt=0. Dout keeps its last value.
- Ack while Valid=0 is ignored.
- Winner selection:
  - Fixed mode: the highest set bit of Din wins, so bit WIDTH-1 has top priority.
  - Round-robin mode: the search runs downward starting at (Last-1) mod WIDTH and wraps from 0 to WIDTH-1. The first set bit found wins.
- Last register (round-robin mode only):
  - Updated to Dout on every transfer, not on grant.
  - Reset value 0, so the first search starts at WIDTH-1, the same as fixed priority.
- Din=0 never produces a grant. Valid=1 always implies exactly one bit set in Gnt.

## Timing
- Latency: a request sampled at edge N appears on Valid/Dout/Gnt after edge N.
- Throughput: one grant per cycle while Ack=1 is held and requests persist.
- Reset mid-grant: the grant is dropped at the reset edge and is never completed. Last returns to 0.
- rst has priority over En and Ack on the same edge.
- A request that drops while its grant is pending is still presented until Ack.
- The grant is a decision only. Requesters that want to be served once must deassert Din themselves.

## Configuration
- PRIO_ARB_RR_EN defined: round-robin selection as described under Operation. The Last register and the rotating search are compiled in.
- PRIO_ARB_RR_EN undefined: fixed MSB-first priority. No Last register. The port list and handshake are identical.

## Test plan
- Reset: rst=1 for 2 cycles with Din=16'hFFFF and En=1 → Valid=0, Gnt=0, Dout=0 throughout. On the first edge after release → Valid=1, Dout=15, Gnt=16'h8000.
- Hold (fixed mode): Din=16'h0041, En=1 → Dout=6, Gnt=16'h0040. Then Ack=0 for 3 cycles while Din changes to 16'h8000 → Dout stays 6. Then Ack=1 for one cycle → next Dout=15.
- Round-robin (PRIO_ARB_RR_EN defined): Din=16'h8101 held, En=1, Ack=1 continuously → Dout sequence 15, 8, 0, 15, 8 on consecutive cycles, with Valid=1 throughout.
- Enable and empty:
  - En=0 with Din=16'hFFFF → Valid stays 0.
  - En driven 0 while Valid=1, then Ack=1 → Valid=0 on the next edge.
  - Din=0 with En=1 → Valid=0.
- Reset mid-operation (round-robin mode): after grants 15 then 8 with Last=15, assert rst while Valid=1 → Valid=0 on the next edge. After release with Din=16'h8101 → Dout=15, confirming Last was reset to 0.
